// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and default widths for the program-counter / fetch-control stage.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

endpackage

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Combinational next-PC priority mux for the RUN state:
// halt > stall > absolute jump > relative jump > increment.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int D = PC_W
) (
  input  logic [D-1:0] i_pc,
  input  logic         i_halt_instr,
  input  logic         i_stall,
  input  logic         i_abs_en,
  input  logic [D-1:0] i_abs_addr,
  input  logic         i_reljump_en,
  input  logic [D-1:0] i_target,
  output logic [D-1:0] o_next_pc,
  output logic         o_halt_req
);

  // Unsigned D-bit addition is already two's-complement modulo 2^D,
  // so a sign-interpreted offset needs no explicit extension.
  always_comb begin
    o_halt_req = i_halt_instr;
    o_next_pc  = i_pc;
    if (i_halt_instr || i_stall) begin
      o_next_pc = i_pc;
    end else if (i_abs_en) begin
      o_next_pc = i_abs_addr;
    end else if (i_reljump_en) begin
      o_next_pc = i_pc + i_target;
    end else begin
      o_next_pc = i_pc + D'(1);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and IDLE/RUN/HALT fetch sequencer driving the instruction-memory
// address, with a saturating count of RUN cycles since the last start.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = CNT_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic [D-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt_instr,
  input  logic          abs_en,
  input  logic [D-1:0]  abs_addr,
  input  logic          reljump_en,
  input  logic [D-1:0]  target,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          done,
  output logic [1:0]    state_o,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  pc_state_t     r_state;
  logic [D-1:0]  r_pc;
  logic          r_done;
  logic [CW-1:0] r_cnt;
  logic [D-1:0]  w_next_pc;
  logic          w_halt_req;

  pc_next_sel #(.D(D)) u_next_sel (
    .i_pc         (r_pc),
    .i_halt_instr (halt_instr),
    .i_stall      (stall),
    .i_abs_en     (abs_en),
    .i_abs_addr   (abs_addr),
    .i_reljump_en (reljump_en),
    .i_target     (target),
    .o_next_pc    (w_next_pc),
    .o_halt_req   (w_halt_req)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= start_addr;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
          r_pc  <= w_next_pc;
          if (w_halt_req) begin
            r_state <= HALT;
            r_done  <= 1'b1;
          end
        end
        HALT: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= start_addr;
            r_cnt   <= '0;
            r_done  <= 1'b0;
          end
        end
        // The unused encoding falls back to IDLE without touching PC or count.
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr    = r_pc;
  assign done        = r_done;
  assign cycle_cnt   = r_cnt;
  assign state_o     = r_state;
  assign fetch_valid = (r_state == RUN);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized run
// compared against a behavioural model of the fetch sequencer.
module tb_pc_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [11:0] start_addr;
  logic        stall;
  logic        halt_instr;
  logic        abs_en;
  logic [11:0] abs_addr;
  logic        reljump_en;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        fetch_valid;
  logic        done;
  logic [1:0]  state_o;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  int m_state = 0;
  int m_pc    = 0;
  int m_cnt   = 0;
  int m_done  = 0;

  pc_fetch_ctrl #(.D(12), .CW(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .start_addr  (start_addr),
    .stall       (stall),
    .halt_instr  (halt_instr),
    .abs_en      (abs_en),
    .abs_addr    (abs_addr),
    .reljump_en  (reljump_en),
    .target      (target),
    .prog_ctr    (prog_ctr),
    .fetch_valid (fetch_valid),
    .done        (done),
    .state_o     (state_o),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 Clk = ~Clk;

  // Reference behaviour: 0=IDLE, 1=RUN, 2=HALT, PC and offsets as plain integers.
  task automatic model_step();
    int off;
    if (Reset === 1'b0) begin
      m_state = 0; m_pc = 0; m_cnt = 0; m_done = 0;
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_pc = int'(start_addr); m_cnt = 0; m_done = 0;
      end
    end else if (m_state == 1) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (halt_instr) begin
        m_state = 2; m_done = 1;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (abs_en) begin
        m_pc = int'(abs_addr);
      end else if (reljump_en) begin
        off  = (int'(target) >= 2048) ? int'(target) - 4096 : int'(target);
        m_pc = (m_pc + off + 4096) % 4096;
      end else begin
        m_pc = (m_pc + 1) % 4096;
      end
    end else if (m_state == 2) begin
      if (start) begin
        m_state = 1; m_pc = int'(start_addr); m_cnt = 0; m_done = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; start_addr = '0; stall = 1'b0; halt_instr = 1'b0;
    abs_en = 1'b0; abs_addr = '0; reljump_en = 1'b0; target = '0;
  endtask

  task automatic jump_to(input logic [11:0] a);
    abs_en = 1'b1; abs_addr = a;
    tick();
    abs_en = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    Reset = 1'b0;
    start = 1'b1;
    tick();
    tick();
    checks++;
    if (state_o !== 2'd0 || prog_ctr !== 12'h000 || cycle_cnt !== 16'd0 ||
        done !== 1'b0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: state=%0d pc=%h cnt=%0d done=%b fv=%b, want 0 000 0 0 0",
               state_o, prog_ctr, cycle_cnt, done, fetch_valid);
    end
  endtask

  task automatic test_increment();
    Reset = 1'b1;
    start = 1'b1; start_addr = 12'h000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (prog_ctr !== 12'(i) || cycle_cnt !== 16'(i) || fetch_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL increment[%0d]: pc=%h cnt=%0d fv=%b done=%b, want pc=%h cnt=%0d fv=1 done=0",
                 i, prog_ctr, cycle_cnt, fetch_valid, done, 12'(i), i);
      end
      tick();
    end
  endtask

  task automatic test_reljump_wrap();
    reljump_en = 1'b1; target = 12'hFFB;
    tick();
    reljump_en = 1'b0;
    checks++;
    if (prog_ctr !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL rel_neg: pc=%h want fff", prog_ctr);
    end
    tick();
    checks++;
    if (prog_ctr !== 12'h000) begin
      errors++;
      $display("[TB] FAIL inc_wrap: pc=%h want 000", prog_ctr);
    end
  endtask

  task automatic test_abs_priority();
    jump_to(12'd10);
    checks++;
    if (prog_ctr !== 12'd10) begin
      errors++;
      $display("[TB] FAIL abs_jump: pc=%h want 00a", prog_ctr);
    end
    reljump_en = 1'b1; target = 12'd20;
    tick();
    checks++;
    if (prog_ctr !== 12'd30) begin
      errors++;
      $display("[TB] FAIL rel_pos: pc=%h want 01e", prog_ctr);
    end
    abs_en = 1'b1; abs_addr = 12'h100; target = 12'hFF6;
    tick();
    abs_en = 1'b0; reljump_en = 1'b0;
    checks++;
    if (prog_ctr !== 12'h100) begin
      errors++;
      $display("[TB] FAIL abs_over_rel: pc=%h want 100", prog_ctr);
    end
  endtask

  task automatic test_stall();
    jump_to(12'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (prog_ctr !== 12'd7 || cycle_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("[TB] FAIL stall[%0d]: pc=%h cnt=%0d, want pc=007 cnt=%0d", i, prog_ctr, cycle_cnt, m_cnt);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (prog_ctr !== 12'd8) begin
      errors++;
      $display("[TB] FAIL stall_release: pc=%h want 008", prog_ctr);
    end
  endtask

  task automatic test_halt_restart();
    tick();
    halt_instr = 1'b1; stall = 1'b1; abs_en = 1'b1; abs_addr = 12'h3C3;
    tick();
    halt_instr = 1'b0; stall = 1'b0; abs_en = 1'b0;
    checks++;
    if (state_o !== 2'd2 || done !== 1'b1 || fetch_valid !== 1'b0 || prog_ctr !== 12'd9) begin
      errors++;
      $display("[TB] FAIL halt: state=%0d done=%b fv=%b pc=%h, want 2 1 0 009",
               state_o, done, fetch_valid, prog_ctr);
    end
    reljump_en = 1'b1; target = 12'h005;
    tick();
    reljump_en = 1'b0;
    checks++;
    if (prog_ctr !== 12'd9 || done !== 1'b1 || cycle_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("[TB] FAIL halt_hold: pc=%h done=%b cnt=%0d, want 009 1 %0d", prog_ctr, done, cycle_cnt, m_cnt);
    end
    start = 1'b1; start_addr = 12'h020;
    tick();
    start = 1'b0;
    checks++;
    if (state_o !== 2'd1 || prog_ctr !== 12'h020 || done !== 1'b0 || cycle_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL restart: state=%0d pc=%h done=%b cnt=%0d, want 1 020 0 0",
               state_o, prog_ctr, done, cycle_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    jump_to(12'h055);
    Reset = 1'b0; start = 1'b1; start_addr = 12'h123;
    tick();
    checks++;
    if (state_o !== 2'd0 || prog_ctr !== 12'h000 || cycle_cnt !== 16'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midrun: state=%0d pc=%h cnt=%0d done=%b, want 0 000 0 0",
               state_o, prog_ctr, cycle_cnt, done);
    end
    tick();
    checks++;
    if (state_o !== 2'd0 || prog_ctr !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_holds: state=%0d pc=%h, want 0 000", state_o, prog_ctr);
    end
    Reset = 1'b1; start = 1'b0;
  endtask

  task automatic test_idle_ignore();
    stall = 1'b0; abs_en = 1'b1; abs_addr = 12'h777; reljump_en = 1'b1; target = 12'h010; halt_instr = 1'b1;
    tick();
    tick();
    clear_inputs();
    checks++;
    if (state_o !== 2'd0 || prog_ctr !== 12'h000 || cycle_cnt !== 16'd0 || fetch_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ignore: state=%0d pc=%h cnt=%0d fv=%b, want 0 000 0 0",
               state_o, prog_ctr, cycle_cnt, fetch_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      Reset      = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      start      = ($urandom_range(99) < 8);
      start_addr = 12'($urandom);
      halt_instr = ($urandom_range(99) < 4);
      stall      = ($urandom_range(99) < 25);
      abs_en     = ($urandom_range(99) < 20);
      abs_addr   = 12'($urandom);
      reljump_en = ($urandom_range(99) < 35);
      target     = 12'($urandom);
      tick();
      checks++;
      if (prog_ctr !== 12'(m_pc) || state_o !== 2'(m_state) || cycle_cnt !== 16'(m_cnt) ||
          done !== 1'(m_done) || fetch_valid !== (m_state == 1)) begin
        errors++;
        $display("[TB] FAIL random[%0d]: pc=%h st=%0d cnt=%0d done=%b fv=%b, want pc=%h st=%0d cnt=%0d done=%0d fv=%0d",
                 n, prog_ctr, state_o, cycle_cnt, done, fetch_valid,
                 12'(m_pc), m_state, m_cnt, m_done, (m_state == 1));
      end
    end
    clear_inputs();
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_increment();
    test_reljump_wrap();
    test_abs_priority();
    test_stall();
    test_halt_restart();
    test_reset_midrun();
    test_idle_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
